datapath: RTL and testbench

//  32-bit single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y and 64-bit Z around an ALU.

---
 rtl/datapath_pkg.sv | 46 ++++
 rtl/datapath_alu.sv | 55 +++++
 rtl/datapath.sv | 178 +++++++++++++++++
 tb/tb_datapath.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: width, ALU op bit positions
// and bus source bit positions (both in priority order, index 0 highest).
package datapath_pkg;

  localparam int WIDTH         = 32;
  localparam int NUM_GPR       = 16;
  localparam int ALU_OP_COUNT  = 13;
  localparam int BUS_SRC_COUNT = 27;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_SHL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12
  } alu_op_e;

  // General registers occupy bus source slots 0..15.
  typedef enum logic [4:0] {
    BUS_R0    = 5'd0,
    BUS_HI    = 5'd16,
    BUS_LO    = 5'd17,
    BUS_ZHIGH = 5'd18,
    BUS_ZLOW  = 5'd19,
    BUS_PC    = 5'd20,
    BUS_IR    = 5'd21,
    BUS_MDR   = 5'd22,
    BUS_IN    = 5'd23,
    BUS_C     = 5'd24,
    BUS_Y     = 5'd25,
    BUS_MAR   = 5'd26
  } bus_src_e;

  function automatic logic [WIDTH-1:0] sext_imm19(input logic [18:0] imm);
    return {{(WIDTH-19){imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
// The lowest-numbered asserted op select wins; none asserted gives zero.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [ALU_OP_COUNT-1:0] op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic [2*WIDTH-1:0]      c
);

  logic        [4:0]         sh;
  logic        [2*WIDTH-1:0] a_ext;
  logic        [2*WIDTH-1:0] b_ext;
  logic        [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic        [WIDTH-1:0]   quo;
  logic        [WIDTH-1:0]   rem;

  assign sh    = b[4:0];
  assign a_s   = a;
  assign b_s   = b;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;

  always_comb begin
    quo = '1;
    rem = a;
    if (b != '0) begin
      quo = a_s / b_s;
      rem = a_s % b_s;
    end
  end

  always_comb begin
    c = '0;
    if (op[OP_AND])       c[WIDTH-1:0] = a & b;
    else if (op[OP_OR])   c[WIDTH-1:0] = a | b;
    else if (op[OP_ADD])  c[WIDTH-1:0] = a + b;
    else if (op[OP_SUB])  c[WIDTH-1:0] = a - b;
    else if (op[OP_MUL])  c = prod;
    else if (op[OP_DIV])  c = {rem, quo};
    else if (op[OP_SHR])  c[WIDTH-1:0] = a >> sh;
    else if (op[OP_SHRA]) c[WIDTH-1:0] = a_s >>> sh;
    else if (op[OP_SHL])  c[WIDTH-1:0] = a << sh;
    else if (op[OP_ROR])  c[WIDTH-1:0] = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
    else if (op[OP_ROL])  c[WIDTH-1:0] = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
    else if (op[OP_NEG])  c[WIDTH-1:0] = '0 - b;
    else if (op[OP_NOT])  c[WIDTH-1:0] = ~b;
  end

endmodule

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: register file, PC/IR/MAR/MDR/HI/LO/Y/Z and
// a priority bus mux, all steered cycle by cycle by external strobes.
module datapath
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             MDRout,
  input  logic             INout,
  input  logic             Cout,
  input  logic             Yout,
  input  logic             MARout,
  input  logic             Read,
  input  logic             IncPC,
  input  logic             AND,
  input  logic             OR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             MUL,
  input  logic             DIV,
  input  logic             SHR,
  input  logic             SHRA,
  input  logic             SHL,
  input  logic             ROR,
  input  logic             ROL,
  input  logic             NEG,
  input  logic             NOT,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             Zin,
  input  logic             Yin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] PC
);

  logic [NUM_GPR-1:0]       r_out;
  logic [NUM_GPR-1:0]       r_in;
  logic [BUS_SRC_COUNT-1:0] bus_sel;
  logic [ALU_OP_COUNT-1:0]  alu_op;
  logic [WIDTH-1:0]         bus_src [BUS_SRC_COUNT];
  logic [WIDTH-1:0]         bus;
  logic [2*WIDTH-1:0]       alu_c;

  logic [WIDTH-1:0]   gpr_q [NUM_GPR];
  logic [WIDTH-1:0]   gpr_d [NUM_GPR];
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]   mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign bus_sel = {MARout, Yout, Cout, INout, MDRout, IRout, PCout,
                    Zlowout, Zhighout, LOout, HIout, r_out};
  assign alu_op  = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND};

  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) bus_src[i] = gpr_q[i];
    bus_src[BUS_HI]    = hi_q;
    bus_src[BUS_LO]    = lo_q;
    bus_src[BUS_ZHIGH] = z_q[2*WIDTH-1:WIDTH];
    bus_src[BUS_ZLOW]  = z_q[WIDTH-1:0];
    bus_src[BUS_PC]    = pc_q;
    bus_src[BUS_IR]    = ir_q;
    bus_src[BUS_MDR]   = mdr_q;
    bus_src[BUS_IN]    = IN;
    bus_src[BUS_C]     = sext_imm19(ir_q[18:0]);
    bus_src[BUS_Y]     = y_q;
    bus_src[BUS_MAR]   = mar_q;
  end

  // Scan from lowest priority up so the highest-priority enabled source is written last.
  always_comb begin
    bus = '0;
    for (int i = BUS_SRC_COUNT - 1; i >= 0; i--) begin
      if (bus_sel[i]) bus = bus_src[i];
    end
  end

  datapath_alu u_alu (
    .op (alu_op),
    .a  (y_q),
    .b  (bus),
    .c  (alu_c)
  );

  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) gpr_d[i] = r_in[i] ? bus : gpr_q[i];
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    y_d   = Yin   ? bus : y_q;
    z_d   = Zin   ? alu_c : z_q;
    mdr_d = mdr_q;
    if (MDRin) mdr_d = Read ? IN : bus;
    pc_d = pc_q;
    if (IncPC)     pc_d = pc_q + WIDTH'(1);
    else if (PCin) pc_d = bus;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

  assign BusMuxOut = bus;
  assign PC        = pc_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: each read-back pushes an expected word,
// a negedge monitor pops it and compares against BusMuxOut or PC.
module tb_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] r_out, r_in;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic        Read, IncPC;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
  logic [31:0] IN, BusMuxOut, PC;

  typedef struct {
    string       name;
    logic [31:0] expVal;
    bit          fromPc;
  } expT;

  expT  expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic obsValid = 1'b0;

  datapath dut (
    .clk(clk), .reset(reset),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout),
    .Cout(Cout), .Yout(Yout), .MARout(MARout),
    .Read(Read), .IncPC(IncPC),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin),
    .Yin(Yin), .MARin(MARin), .MDRin(MDRin),
    .IN(IN), .BusMuxOut(BusMuxOut), .PC(PC)
  );

  task automatic clearStrobes();
    r_out = '0; r_in = '0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; IRout = 0;
    MDRout = 0; INout = 0; Cout = 0; Yout = 0; MARout = 0;
    Read = 0; IncPC = 0;
    AND = 0; OR = 0; ADD = 0; SUB = 0; MUL = 0; DIV = 0; SHR = 0; SHRA = 0;
    SHL = 0; ROR = 0; ROL = 0; NEG = 0; NOT = 0;
    HIin = 0; LOin = 0; PCin = 0; IRin = 0; Zin = 0; Yin = 0; MARin = 0; MDRin = 0;
  endtask

  // One clock: the strobes set by the caller are sampled at this edge, then dropped.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearStrobes();
    obsValid = 1'b0;
  endtask

  // Caller selects the bus source first; the monitor checks it this cycle.
  task automatic checkOutput(input string name, input logic [31:0] expVal, input bit fromPc);
    expT e;
    e.name   = name;
    e.expVal = expVal;
    e.fromPc = fromPc;
    expQ.push_back(e);
    obsValid = 1'b1;
    applyStimulus();
  endtask

  always @(negedge clk) begin
    if (obsValid) begin
      expT         e;
      logic [31:0] actual;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output got %h want nothing queued", BusMuxOut);
      end else begin
        e = expQ.pop_front();
        actual = e.fromPc ? PC : BusMuxOut;
        if (actual !== e.expVal) begin
          errors++;
          $display("[TB] FAIL %s got %h want %h", e.name, actual, e.expVal);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    IN    = '0;
    clearStrobes();
    applyStimulus();
    reset = 1'b1;

    // Reset state
    checkOutput("pc_reset", 32'h0, 1'b1);
    checkOutput("bus_idle", 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      r_out[i] = 1'b1;
      checkOutput($sformatf("r%0d_reset", i), 32'h0, 1'b0);
    end
    HIout = 1;  checkOutput("hi_reset", 32'h0, 1'b0);
    LOout = 1;  checkOutput("lo_reset", 32'h0, 1'b0);
    Zhighout = 1; checkOutput("zhigh_reset", 32'h0, 1'b0);
    Zlowout = 1;  checkOutput("zlow_reset", 32'h0, 1'b0);
    IRout = 1;  checkOutput("ir_reset", 32'h0, 1'b0);
    MDRout = 1; checkOutput("mdr_reset", 32'h0, 1'b0);
    Yout = 1;   checkOutput("y_reset", 32'h0, 1'b0);
    MARout = 1; checkOutput("mar_reset", 32'h0, 1'b0);

    // Register loads through MDR
    IN = 32'h22; Read = 1; MDRin = 1; applyStimulus();
    MDRout = 1; r_in[2] = 1; applyStimulus();
    r_out[2] = 1; checkOutput("r2_load", 32'h22, 1'b0);
    IN = 32'h24; Read = 1; MDRin = 1; applyStimulus();
    MDRout = 1; r_in[6] = 1; applyStimulus();
    r_out[6] = 1; checkOutput("r6_load", 32'h24, 1'b0);
    IN = 32'h28; Read = 1; MDRin = 1; applyStimulus();
    MDRout = 1; r_in[4] = 1; applyStimulus();
    r_out[4] = 1; checkOutput("r4_load", 32'h28, 1'b0);

    // Division
    r_out[2] = 1; Yin = 1; applyStimulus();
    r_out[6] = 1; DIV = 1; Zin = 1; applyStimulus();
    Zlowout = 1;  checkOutput("div_quo", 32'h0, 1'b0);
    Zhighout = 1; checkOutput("div_rem", 32'h22, 1'b0);
    IN = 32'hFFFFFFF9; Read = 1; MDRin = 1; applyStimulus();
    MDRout = 1; Yin = 1; applyStimulus();
    IN = 32'h2; INout = 1; DIV = 1; Zin = 1; applyStimulus();
    Zlowout = 1;  checkOutput("div_neg_quo", 32'hFFFFFFFD, 1'b0);
    Zhighout = 1; checkOutput("div_neg_rem", 32'hFFFFFFFF, 1'b0);
    DIV = 1; Zin = 1; applyStimulus();
    Zlowout = 1;  checkOutput("div0_quo", 32'hFFFFFFFF, 1'b0);
    Zhighout = 1; checkOutput("div0_rem", 32'hFFFFFFF9, 1'b0);

    // Multiply and HI/LO transfer
    IN = 32'hFFFFFFFE; INout = 1; Yin = 1; applyStimulus();
    IN = 32'h3; INout = 1; MUL = 1; Zin = 1; applyStimulus();
    Zhighout = 1; checkOutput("mul_hi", 32'hFFFFFFFF, 1'b0);
    Zlowout = 1;  checkOutput("mul_lo", 32'hFFFFFFFA, 1'b0);
    Zhighout = 1; HIin = 1; applyStimulus();
    Zlowout = 1;  LOin = 1; applyStimulus();
    HIout = 1; checkOutput("hi_reg", 32'hFFFFFFFF, 1'b0);
    LOout = 1; checkOutput("lo_reg", 32'hFFFFFFFA, 1'b0);

    // Instruction fetch
    PCout = 1; IncPC = 1; PCin = 1; MARin = 1; applyStimulus();
    checkOutput("fetch_pc", 32'h1, 1'b1);
    MARout = 1; checkOutput("fetch_mar0", 32'h0, 1'b0);
    PCout = 1; IncPC = 1; MARin = 1; applyStimulus();
    MARout = 1; checkOutput("fetch_mar1", 32'h1, 1'b0);
    checkOutput("fetch_pc2", 32'h2, 1'b1);
    IN = 32'h79300000; Read = 1; MDRin = 1; applyStimulus();
    MDRout = 1; IRin = 1; applyStimulus();
    IRout = 1; checkOutput("ir_load", 32'h79300000, 1'b0);
    IN = 32'h00040005; INout = 1; IRin = 1; applyStimulus();
    Cout = 1; checkOutput("c_sext", 32'hFFFC0005, 1'b0);

    // PC wrap and IncPC priority
    IN = 32'hFFFFFFFF; INout = 1; PCin = 1; applyStimulus();
    checkOutput("pc_load", 32'hFFFFFFFF, 1'b1);
    IncPC = 1; applyStimulus();
    checkOutput("pc_wrap", 32'h0, 1'b1);
    IN = 32'h55; INout = 1; IncPC = 1; PCin = 1; applyStimulus();
    checkOutput("incpc_prio", 32'h1, 1'b1);

    // Shifts, rotates, op priority
    IN = 32'h80000001; INout = 1; Yin = 1; applyStimulus();
    IN = 32'h1; INout = 1; SHRA = 1; Zin = 1; applyStimulus();
    Zlowout = 1;  checkOutput("shra", 32'hC0000000, 1'b0);
    Zhighout = 1; checkOutput("shra_hi", 32'h0, 1'b0);
    IN = 32'h1; INout = 1; ROL = 1; Zin = 1; applyStimulus();
    Zlowout = 1; checkOutput("rol", 32'h00000003, 1'b0);
    IN = 32'h2; INout = 1; SUB = 1; Zin = 1; applyStimulus();
    Zlowout = 1; checkOutput("sub", 32'h7FFFFFFF, 1'b0);
    IN = 32'h1; INout = 1; ADD = 1; SUB = 1; Zin = 1; applyStimulus();
    Zlowout = 1; checkOutput("op_prio", 32'h80000002, 1'b0);
    IN = 32'h1; INout = 1; NEG = 1; Zin = 1; applyStimulus();
    Zlowout = 1; checkOutput("neg", 32'hFFFFFFFF, 1'b0);

    // Bus priority and multiple loads in one cycle
    IN = 32'h11; INout = 1; r_in[1] = 1; applyStimulus();
    IN = 32'h33; INout = 1; r_in[3] = 1; applyStimulus();
    r_out[1] = 1; r_out[3] = 1; checkOutput("bus_prio", 32'h11, 1'b0);
    IN = 32'hABCD; INout = 1; r_in[7] = 1; r_in[8] = 1; applyStimulus();
    r_out[7] = 1; checkOutput("multi_r7", 32'hABCD, 1'b0);
    r_out[8] = 1; checkOutput("multi_r8", 32'hABCD, 1'b0);

    // Reset overrides load enables
    IN = 32'h5; Read = 1; MDRin = 1; INout = 1; r_in[0] = 1; IncPC = 1;
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    MDRout = 1;   checkOutput("rst_mdr", 32'h0, 1'b0);
    r_out[0] = 1; checkOutput("rst_r0", 32'h0, 1'b0);
    checkOutput("rst_pc", 32'h0, 1'b1);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
